// File: rtl/comp_sub_seq_if.sv
// Operand/result handshake bundle for comp_sub_seq: operand pair in, packed complex result out.
// Packing: [W-1:FW] = real part, [FW-1:0] = imaginary part.
interface comp_sub_seq_if #(
  parameter bit double = 1'b0
);
  localparam int FW = double ? 64 : 32;
  localparam int W  = 2 * FW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/comp_sub_seq.sv
// Sequential complex subtractor: one shared IEEE-754 adder is used for the real part,
// then the imaginary part. Round-to-nearest-even, subnormals supported, canonical quiet NaN.
module fpu_add #(
  parameter bit       double = 1'b0,
  localparam int      FW     = double ? 64 : 32
) (
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic [FW-1:0] result
);
  localparam int EW = double ? 11 : 8;
  localparam int MW = FW - EW - 1;
  localparam int SW = MW + 5;
  localparam logic [EW:0] E_ONE = (EW+1)'(1);
  localparam logic [EW:0] E_MAX = {1'b0, {EW{1'b1}}};
  localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic          sa, sb, sl, ss;
  logic [EW-1:0] ea, eb, el, es, el_e, es_e, d;
  logic [MW-1:0] fa, fb, fl, fs;
  logic          a_nan, b_nan, a_inf, b_inf, swap, sub, sticky;
  logic [SW-1:0] ml, ms, ms_sh, ms_al, sum;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_nan = (&ea) & (|fa);
  assign b_nan = (&eb) & (|fb);
  assign a_inf = (&ea) & ~(|fa);
  assign b_inf = (&eb) & ~(|fb);

  // Order operands by magnitude so the aligned subtraction never goes negative.
  assign swap = b[FW-2:0] > a[FW-2:0];
  assign {sl, el, fl} = swap ? b : a;
  assign {ss, es, fs} = swap ? a : b;
  assign sub  = sl ^ ss;
  assign el_e = (el == '0) ? EW'(1) : el;
  assign es_e = (es == '0) ? EW'(1) : es;
  assign d    = el_e - es_e;

  // Layout: carry | hidden | fraction | guard, round, sticky
  assign ml     = {1'b0, |el, fl, 3'b000};
  assign ms     = {1'b0, |es, fs, 3'b000};
  assign ms_sh  = ms >> d;
  assign sticky = (ms_sh << d) != ms;
  assign ms_al  = ms_sh | SW'(sticky);
  assign sum    = sub ? (ml - ms_al) : (ml + ms_al);

  logic [EW:0]   lz, sh, el_x, e_n, e_f;
  logic          found, round_up;
  logic [SW-2:0] n;
  logic [MW+1:0] m_r;
  logic [MW-1:0] f_f;

  always_comb begin
    lz       = '0;
    found    = 1'b0;
    sh       = '0;
    el_x     = {1'b0, el_e};
    n        = '0;
    e_n      = '0;
    e_f      = '0;
    f_f      = '0;
    m_r      = '0;
    round_up = 1'b0;
    for (int i = SW - 2; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + E_ONE;
      end
    end
    if (sum[SW-1]) begin
      n   = {sum[SW-1:2], sum[1] | sum[0]};
      e_n = el_x + E_ONE;
    end else begin
      // Normalisation stops at exponent 1; anything still unnormalised is subnormal.
      sh  = (lz < el_x) ? lz : (el_x - E_ONE);
      n   = sum[SW-2:0] << sh;
      e_n = el_x - sh;
    end
    round_up = n[2] & (n[1] | n[0] | n[3]);
    m_r      = {1'b0, n[SW-2:3]} + (MW+2)'(round_up);
    if (m_r[MW+1]) begin
      e_f = e_n + E_ONE;
      f_f = m_r[MW:1];
    end else begin
      e_f = m_r[MW] ? e_n : '0;
      f_f = m_r[MW-1:0];
    end

    if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) result = QNAN;
    else if (a_inf)                                  result = a;
    else if (b_inf)                                  result = b;
    else if (sum == '0)                              result = {sub ? 1'b0 : sl, {(FW-1){1'b0}}};
    else if (e_f >= E_MAX)                           result = {sl, {EW{1'b1}}, {MW{1'b0}}};
    else                                             result = {sl, e_f[EW-1:0], f_f};
  end
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RE    | real part through the adder
// IM    | imaginary part through the adder
// DONE  | result presented, held until out_ready
module comp_sub_seq #(
  parameter bit double = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  comp_sub_seq_if.slave bus
);
  localparam int FW = double ? 64 : 32;
  localparam int W  = 2 * FW;

  typedef enum logic [1:0] {IDLE, RE, IM, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r, b_r, result_r;
  logic          out_valid_r;
  logic [FW-1:0] x, y, y_neg, sum;

  assign x     = (state == IM) ? a_r[FW-1:0] : a_r[W-1:FW];
  assign y     = (state == IM) ? b_r[FW-1:0] : b_r[W-1:FW];
  assign y_neg = {~y[FW-1], y[FW-2:0]};

  fpu_add #(.double(double)) u_fpu (
    .a      (x),
    .b      (y_neg),
    .result (sum)
  );

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            state <= RE;
          end
        end
        RE: begin
          result_r[W-1:FW] <= sum;
          state            <= IM;
        end
        IM: begin
          result_r[FW-1:0] <= sum;
          out_valid_r      <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          // Accepting here as the result leaves removes the IDLE bubble.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              a_r   <= bus.a;
              b_r   <= bus.b;
              state <= RE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
